// File: rtl/postcode_pkg.sv
// postcode shared definitions: timing defaults, counter widths and the
// receive group-decode states used by the POST interface bridge.
package postcode_pkg;

    // 10 us and 160 us at 48 MHz
    localparam int GAP_CYCLES_DEF   = 480;
    localparam int ABORT_CYCLES_DEF = 7680;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int GAP_W     = cnt_w(ABORT_CYCLES_DEF);
    localparam int BIT_W     = 3;
    localparam int FRAME_W   = 9;
    localparam int FRAME_CW  = cnt_w(FRAME_W);

    // Pulses seen in the current group
    typedef enum logic [1:0] {
        GRP_IDLE,
        GRP_ONE,
        GRP_TWO,
        GRP_ERR
    } grp_e;

endpackage

// File: rtl/postcode_sync.sv
// TESTREQ synchroniser with rise/fall strobes.
// Ports: clk, reset (sync, high), testreq (async in), req (clean level),
// rise/fall (one-cycle strobes). POSTCODE_GLITCH_FILTER_EN adds a deglitcher.
module postcode_sync (
    input  logic clk,
    input  logic reset,
    input  logic testreq,
    output logic req,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic lvl;
    logic hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= testreq;
            s2 <= s1;
        end
    end

`ifdef POSTCODE_GLITCH_FILTER_EN
    logic s3;
    logic s4;
    logic filt;

    // Level only moves once three consecutive samples agree
    always_ff @(posedge clk) begin
        if (reset) begin
            s3   <= 1'b0;
            s4   <= 1'b0;
            filt <= 1'b0;
        end else begin
            s3 <= s2;
            s4 <= s3;
            if (s2 == s3 && s3 == s4)
                filt <= s2;
        end
    end

    assign lvl = filt;
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            hist <= 1'b0;
        else
            hist <= lvl;
    end

    assign req  = lvl;
    assign rise = lvl & ~hist;
    assign fall = ~lvl & hist;

endmodule

// File: rtl/postcode.sv
// Acorn POST TESTREQ/TESTACK bridge: decodes pulse-group bytes into rxout,
// serialises txin back on testack. Ports: refclk, reset, testreq, testack,
// rxout, rxfull, rxreset, txin, txempty, txstart.
// Optional deglitch stage: define POSTCODE_GLITCH_FILTER_EN.
module postcode
    import postcode_pkg::*;
#(
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int ABORT_CYCLES = ABORT_CYCLES_DEF
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       testreq,
    output logic       testack,
    output logic [7:0] rxout,
    output logic       rxfull,
    input  logic       rxreset,
    input  logic [7:0] txin,
    output logic       txempty,
    input  logic       txstart
);

    localparam int GW = cnt_w(ABORT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] ABORT_LAST = GW'(ABORT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_SAT    = GW'(ABORT_CYCLES);

    logic req;
    logic rise;
    logic fall;

    postcode_sync u_sync (
        .clk     (refclk),
        .reset   (reset),
        .testreq (testreq),
        .req     (req),
        .rise    (rise),
        .fall    (fall)
    );

    // ---------------- receive ----------------
    logic [GW-1:0]    gap_cnt;
    grp_e             grp;
    grp_e             grp_nxt;
    logic             close;
    logic             abort_hit;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       rx_sh;
    logic [7:0]       rx_byte;
    logic             done;

    // gap_cnt holds idle cycles seen before the current one
    assign close     = !rise && gap_cnt == GAP_LAST && grp != GRP_IDLE;
    assign abort_hit = !rise && gap_cnt == ABORT_LAST;
    assign rx_byte   = {rx_sh[6:0], grp == GRP_TWO};
    assign done      = close && grp != GRP_ERR
                     && bit_cnt == BIT_W'(7);

    always_ff @(posedge refclk) begin
        if (reset)
            gap_cnt <= '0;
        else if (rise)
            gap_cnt <= '0;
        else if (gap_cnt != GAP_SAT)
            gap_cnt <= gap_cnt + GW'(1);
    end

    always_ff @(posedge refclk) begin
        if (reset)
            grp <= GRP_IDLE;
        else
            grp <= grp_nxt;
    end

    always_comb begin
        grp_nxt = grp;
        if (rise) begin
            unique case (grp)
                GRP_IDLE: grp_nxt = GRP_ONE;
                GRP_ONE:  grp_nxt = GRP_TWO;
                GRP_TWO:  grp_nxt = GRP_ERR;
                GRP_ERR:  grp_nxt = GRP_ERR;
            endcase
        end else if (close) begin
            grp_nxt = GRP_IDLE;
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
            rxout   <= '0;
            rxfull  <= 1'b0;
        end else begin
            if (close) begin
                if (grp == GRP_ERR) begin
                    bit_cnt <= '0;
                end else begin
                    rx_sh   <= rx_byte;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end else if (abort_hit) begin
                bit_cnt <= '0;
            end

            // a completion wins over a coincident consume
            if (done && (!rxfull || rxreset)) begin
                rxout  <= rx_byte;
                rxfull <= 1'b1;
            end else if (rxreset) begin
                rxfull <= 1'b0;
            end
        end
    end

    // ---------------- transmit ----------------
    logic [FRAME_W-1:0]  tx_frame;
    logic [FRAME_CW-1:0] tx_left;

    always_ff @(posedge refclk) begin
        if (reset) begin
            tx_frame <= '0;
            tx_left  <= '0;
            txempty  <= 1'b1;
            testack  <= 1'b0;
        end else begin
            if (txempty) begin
                if (txstart) begin
                    tx_frame <= {1'b0, txin};
                    tx_left  <= FRAME_CW'(FRAME_W);
                    txempty  <= 1'b0;
                end
            end else if (fall) begin
                tx_frame <= {tx_frame[FRAME_W-2:0], 1'b0};
                tx_left  <= tx_left - FRAME_CW'(1);
                if (tx_left == FRAME_CW'(1))
                    txempty <= 1'b1;
            end

            // idle echoes presence; busy gates the frame bit
            testack <= txempty ? req : (req & tx_frame[FRAME_W-1]);
        end
    end

endmodule

// File: tb/tb_postcode.sv
// Self-checking bench for postcode: directed pulse groups and TX frames,
// a byte-level rx model, a frame-level tx model and a per-cycle compare.
module tb_postcode;

    localparam int GAP   = 48;
    localparam int ABORT = 768;
    localparam int PH    = 4;
    localparam int PL    = 4;

    logic       refclk = 1'b0;
    logic       reset;
    logic       testreq;
    logic       testack;
    logic [7:0] rxout;
    logic       rxfull;
    logic       rxreset;
    logic [7:0] txin;
    logic       txempty;
    logic       txstart;

    always #5 refclk = ~refclk;

    postcode #(
        .GAP_CYCLES   (GAP),
        .ABORT_CYCLES (ABORT)
    ) dut (
        .refclk  (refclk),
        .reset   (reset),
        .testreq (testreq),
        .testack (testack),
        .rxout   (rxout),
        .rxfull  (rxfull),
        .rxreset (rxreset),
        .txin    (txin),
        .txempty (txempty),
        .txstart (txstart)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_rxout  = 8'h00;
    logic       m_rxfull = 1'b0;
    logic [7:0] m_sh     = 8'h00;
    int         m_bits   = 0;

    logic [8:0] m_frame = '0;
    int         m_idx   = 0;
    logic       m_busy  = 1'b0;

    logic [3:0] req_h = '0;
    logic       st_q  = 1'b0;
    logic [7:0] txin_q = '0;
    logic [8:0] exp_bits = 9'b0_1100_0011;

    always @(posedge refclk) begin
        req_h  <= {req_h[2:0], testreq};
        st_q   <= txstart;
        txin_q <= txin;
    end

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_group(int n);
        if (n >= 3) begin
            m_bits = 0;
        end else begin
            m_sh = {m_sh[6:0], n == 2};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (!m_rxfull) begin
                    m_rxout  = m_sh;
                    m_rxfull = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_loop();
        logic old_busy;
        logic exp_ack;
        forever begin
            @(negedge refclk);
            old_busy = m_busy;
            exp_ack  = old_busy ? (req_h[2] & m_frame[8-m_idx]) : req_h[2];
            if (old_busy && req_h[3] && !req_h[2]) begin
                m_idx++;
                if (m_idx == 9)
                    m_busy = 1'b0;
            end
            if (st_q && !old_busy) begin
                m_frame = {1'b0, txin_q};
                m_idx   = 0;
                m_busy  = 1'b1;
            end
            if (chk_en) begin
                check("testack", 8'(testack), 8'(exp_ack));
                check("txempty", 8'(txempty), 8'(!m_busy));
                check("rxfull",  8'(rxfull),  8'(m_rxfull));
                check("rxout",   rxout,       m_rxout);
            end
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // rr: rxreset coincides with the closing edge; tc: pin close timing
    task automatic send_group(int n, bit rr = 1'b0, bit tc = 1'b0);
        for (int p = 0; p < n; p++) begin
            testreq = 1'b1;
            wait_cyc(PH);
            testreq = 1'b0;
            if (p < n - 1)
                wait_cyc(PL);
        end
        wait_cyc(GAP + 2 - PH);
        if (tc)
            check("close_early", 8'(rxfull), 8'h00);
        if (rr)
            rxreset = 1'b1;
        wait_cyc(1);
        rxreset = 1'b0;
        if (tc)
            check("close_edge", 8'(rxfull), 8'h01);
        if (rr)
            m_rxfull = 1'b0;
        model_group(n);
        wait_cyc(GAP);
    endtask

    task automatic send_byte(logic [7:0] b, bit rr = 1'b0, bit tc = 1'b0);
        for (int i = 7; i >= 0; i--)
            send_group(b[i] ? 2 : 1, rr && i == 0, tc && i == 0);
    endtask

    task automatic rx_consume();
        rxreset = 1'b1;
        wait_cyc(1);
        rxreset  = 1'b0;
        m_rxfull = 1'b0;
        check("rxreset", 8'(rxfull), 8'h00);
    endtask

    initial begin
        reset   = 1'b1;
        testreq = 1'b0;
        rxreset = 1'b0;
        txstart = 1'b0;
        txin    = 8'h00;
        fork
            compare_loop();
        join_none
        wait_cyc(4);
        reset = 1'b0;
        check("rst_testack", 8'(testack), 8'h00);
        check("rst_rxfull",  8'(rxfull),  8'h00);
        check("rst_txempty", 8'(txempty), 8'h01);
        check("rst_rxout",   rxout,       8'h00);
        wait_cyc(2);
        chk_en = 1'b1;

        // presence echo, 3 cycles late on both edges
        testreq = 1'b1;
        wait_cyc(2);
        check("echo_rise2", 8'(testack), 8'h00);
        wait_cyc(1);
        check("echo_rise3", 8'(testack), 8'h01);
        wait_cyc(1);
        testreq = 1'b0;
        wait_cyc(2);
        check("echo_fall2", 8'(testack), 8'h01);
        wait_cyc(1);
        check("echo_fall3", 8'(testack), 8'h00);
        wait_cyc(GAP + 10);
        model_group(1);
        wait_cyc(ABORT + 10);
        m_bits = 0;

        send_byte(8'hA5, 1'b0, 1'b1);
        check("rx_a5", rxout, 8'hA5);
        check("rx_a5_full", 8'(rxfull), 8'h01);
        rx_consume();

        send_byte(8'h12);
        check("rx_12", rxout, 8'h12);
        send_byte(8'h34);
        check("rx_34_dropped", rxout, 8'h12);
        send_byte(8'h56, 1'b1);
        check("rx_coincide", rxout, 8'h56);
        check("rx_coincide_full", 8'(rxfull), 8'h01);
        rx_consume();

        send_group(1);
        send_group(2);
        send_group(1);
        send_group(3);
        send_byte(8'h0F);
        check("rx_0f", rxout, 8'h0F);
        rx_consume();

        // transmit 0xC3
        txin    = 8'hC3;
        txstart = 1'b1;
        wait_cyc(1);
        txstart = 1'b0;
        check("tx_busy", 8'(txempty), 8'h00);
        for (int i = 0; i < 9; i++) begin
            testreq = 1'b1;
            wait_cyc(3);
            check("tx_bit", 8'(testack), 8'(exp_bits[8-i]));
            wait_cyc(PH - 3);
            testreq = 1'b0;
            if (i == 8) begin
                wait_cyc(2);
                check("tx_end_early", 8'(txempty), 8'h00);
                wait_cyc(1);
                check("tx_end", 8'(txempty), 8'h01);
                wait_cyc(PL - 3);
            end else begin
                if (i == 3) begin
                    txin    = 8'hFF;
                    txstart = 1'b1;
                    wait_cyc(1);
                    txstart = 1'b0;
                    wait_cyc(PL - 1);
                    check("tx_ignored", 8'(txempty), 8'h00);
                end else begin
                    wait_cyc(PL);
                end
            end
        end
        wait_cyc(GAP + 10);
        model_group(9);

        // abort a half byte, then a clean byte
        send_group(2);
        send_group(1);
        send_group(2);
        send_group(2);
        wait_cyc(ABORT + 10);
        m_bits = 0;
        send_byte(8'h81);
        check("rx_81", rxout, 8'h81);

        wait_cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
